// File: rtl/dcache_pkg.sv
// Shared types for the data cache: funct3 access sizes, FSM states and lane helpers.
// Pure declarations and combinational functions; no timing or flow control.
package dcache_pkg;

  typedef enum logic [2:0] {
    ACC_B  = 3'b000,
    ACC_H  = 3'b001,
    ACC_W  = 3'b010,
    ACC_BU = 3'b100,
    ACC_HU = 3'b101
  } acc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE
  } state_t;

  // Undefined funct3 codes fall through to word behaviour.
  function automatic logic [3:0] calc_be(input logic [2:0] typ, input logic [1:0] a);
    case (typ)
      ACC_B, ACC_BU: calc_be = 4'b0001 << a;
      ACC_H, ACC_HU: calc_be = a[1] ? 4'b1100 : 4'b0011;
      default:       calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] a);
    case (typ)
      ACC_B, ACC_BU: is_misaligned = 1'b0;
      ACC_H, ACC_HU: is_misaligned = a[0];
      default:       is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dcache_direct_mapped_if.sv
// CPU-side and memory-side bundles for the data cache.
// The CPU holds its request stable while stall is high; memory accepts a beat on mem_ready.
interface dcache_cpu_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [2:0]               cpu_type;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wd;
  logic [DATA_WIDTH-1:0]    cpu_rd;
  logic                     stall;
  logic                     misaligned;

  modport master (
    output cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wd,
    input  cpu_rd, stall, misaligned
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wd,
    output cpu_rd, stall, misaligned
  );
endinterface

interface dcache_mem_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [3:0]               mem_be;
  logic [DATA_WIDTH-1:0]    mem_rd;
  logic                     mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wd, mem_be,
    input  mem_rd, mem_ready
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wd, mem_be,
    output mem_rd, mem_ready
  );
endinterface

// File: rtl/lsu_align.sv
// RV32I load extract/extend and store lane shift with byte enables; purely combinational.
// No state and no flow control; shared with the uncached I/O path.
module lsu_align
  import dcache_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data,
  output logic [3:0]  o_be,
  output logic        o_misaligned
);

  logic [4:0]  w_shamt;
  logic [31:0] w_load_sh;
  logic [31:0] w_lane_mask;

  assign w_shamt      = {i_addr_lo, 3'b000};
  assign w_load_sh    = i_load_word >> w_shamt;
  assign o_be         = calc_be(i_type, i_addr_lo);
  assign o_misaligned = is_misaligned(i_type, i_addr_lo);

  always_comb begin
    o_load_data = w_load_sh;
    case (i_type)
      ACC_B:   o_load_data = {{24{w_load_sh[7]}}, w_load_sh[7:0]};
      ACC_BU:  o_load_data = {24'h0, w_load_sh[7:0]};
      ACC_H:   o_load_data = {{16{w_load_sh[15]}}, w_load_sh[15:0]};
      ACC_HU:  o_load_data = {16'h0, w_load_sh[15:0]};
      default: o_load_data = w_load_sh;
    endcase
  end

  // Masking after the shift keeps the lanes outside the access at zero.
  assign w_lane_mask  = {{8{o_be[3]}}, {8{o_be[2]}}, {8{o_be[1]}}, {8{o_be[0]}}};
  assign o_store_data = (i_store_data << w_shamt) & w_lane_mask;

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache; load hits return in the same cycle.
// Misses and all stores hold stall high until the backing memory has completed every beat.
module dcache_direct_mapped
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 64,
  parameter int LINE_WORDS    = 4
) (
  input  logic          clk,
  input  logic          rst,
  dcache_cpu_if.slave   cpu,
  dcache_mem_if.master  mem
);

  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDRESS_WIDTH - IDX_W - OFF_W;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t                   r_state, w_next;
  logic [BEAT_W-1:0]        r_beat;
  logic [SETS-1:0]          r_valid;
  logic [TAG_W-1:0]         r_tag  [SETS];
  logic [DATA_WIDTH-1:0]    r_data [SETS][LINE_WORDS];
  logic                     r_wr_done;

  logic [IDX_W-1:0]         w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic [BEAT_W-1:0]        w_word;
  logic                     w_hit;
  logic [DATA_WIDTH-1:0]    w_hit_word;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic [DATA_WIDTH-1:0]    w_store_lane;
  logic [3:0]               w_be;
  logic                     w_mis_raw;
  logic                     w_access;
  logic [ADDRESS_WIDTH-1:0] w_refill_addr;
  logic                     w_beat_wr;
  logic                     w_last_beat;
  logic                     w_start_refill;
  logic                     w_store_hit;
  logic                     w_stall;
  logic                     w_misaligned;
  logic [DATA_WIDTH-1:0]    w_cpu_rd;
  logic                     w_mem_req;
  logic                     w_mem_we;
  logic [ADDRESS_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0]    w_mem_wd;
  logic [3:0]               w_mem_be;

  assign w_idx = cpu.cpu_addr[OFF_W +: IDX_W];
  assign w_tag = cpu.cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];

  if (LINE_WORDS > 1) begin : g_word_sel
    assign w_word = cpu.cpu_addr[OFF_W-1:2];
  end else begin : g_word_fixed
    assign w_word = '0;
  end

  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_word    = r_data[w_idx][w_word];
  assign w_access      = cpu.cpu_req && !w_mis_raw;
  assign w_last_beat   = (r_beat == LAST_BEAT);
  assign w_refill_addr = {cpu.cpu_addr[ADDRESS_WIDTH-1:OFF_W], OFF_W'(0)}
                       | (ADDRESS_WIDTH'(r_beat) << 2);

  lsu_align u_lsu_align (
    .i_type       (cpu.cpu_type),
    .i_addr_lo    (cpu.cpu_addr[1:0]),
    .i_load_word  (w_hit_word),
    .i_store_data (cpu.cpu_wd),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_lane),
    .o_be         (w_be),
    .o_misaligned (w_mis_raw)
  );

  always_comb begin
    w_next         = r_state;
    w_stall        = 1'b0;
    w_misaligned   = 1'b0;
    w_cpu_rd       = '0;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = '0;
    w_mem_wd       = '0;
    w_mem_be       = '0;
    w_beat_wr      = 1'b0;
    w_start_refill = 1'b0;
    w_store_hit    = 1'b0;
    if (!rst) begin
      w_misaligned = cpu.cpu_req && w_mis_raw;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            // r_wr_done marks the store still presented in the cycle its write completed.
            if (cpu.cpu_we) begin
              if (!r_wr_done) begin
                w_stall     = 1'b1;
                w_next      = ST_WRITE;
                w_store_hit = w_hit;
              end
            end else if (w_hit) begin
              w_cpu_rd = w_load_data;
            end else begin
              w_stall        = 1'b1;
              w_start_refill = 1'b1;
              w_next         = ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          w_stall    = 1'b1;
          w_mem_req  = 1'b1;
          w_mem_addr = w_refill_addr;
          if (mem.mem_ready) begin
            w_beat_wr = 1'b1;
            if (w_last_beat) w_next = ST_IDLE;
          end
        end
        ST_WRITE: begin
          w_stall    = 1'b1;
          w_mem_req  = 1'b1;
          w_mem_we   = 1'b1;
          w_mem_addr = {cpu.cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
          w_mem_wd   = w_store_lane;
          w_mem_be   = w_be;
          if (mem.mem_ready) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_valid   <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wr_done <= (r_state == ST_WRITE) && mem.mem_ready;
      // The line is invalid while it is being overwritten so a partial refill never hits.
      if (w_start_refill) r_valid[w_idx] <= 1'b0;
      if (w_beat_wr) begin
        if (w_last_beat) begin
          r_beat         <= '0;
          r_valid[w_idx] <= 1'b1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_wr) begin
      r_data[w_idx][r_beat] <= mem.mem_rd;
      if (w_last_beat) r_tag[w_idx] <= w_tag;
    end else if (w_store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_data[w_idx][w_word][8*b +: 8] <= w_store_lane[8*b +: 8];
      end
    end
  end

  assign cpu.cpu_rd     = w_cpu_rd;
  assign cpu.stall      = w_stall;
  assign cpu.misaligned = w_misaligned;
  assign mem.mem_req    = w_mem_req;
  assign mem.mem_we     = w_mem_we;
  assign mem.mem_addr   = w_mem_addr;
  assign mem.mem_wd     = w_mem_wd;
  assign mem.mem_be     = w_mem_be;

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Parametrised successor to the flat byte-array data memory.
- A direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and a multi-cycle backing memory.
- Generalises the old 1-bit byte/word select to full RV32I load/store sizing (byte, half, word; signed/unsigned).
- Adds a refill FSM, a memory handshake and a pipeline stall.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width. Fixed at 32; lane logic assumes 4 bytes.
- SETS, 64, number of lines. Power of 2.
- LINE_WORDS, 4, words per line. Power of 2, at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  memory-stage access valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- cpu_addr  in  ADDRESS_WIDTH  byte address. Held stable by the CPU while stall=1.
- cpu_wd  in  DATA_WIDTH  store data, right-aligned.
- cpu_rd  out  DATA_WIDTH  load data, sized and extended.
- stall  out  1  freeze the pipeline.
- misaligned  out  1  access is not naturally aligned.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write.
- mem_addr  out  ADDRESS_WIDTH  word-aligned backing address.
- mem_wd  out  DATA_WIDTH  write data, lane-positioned.
- mem_be  out  4  byte enables for the write.
- mem_rd  in  DATA_WIDTH  read beat data.
- mem_ready  in  1  beat or write accepted this cycle.

Behaviour:
- Address split:
  - offset = log2(LINE_WORDS)+2 bits.
  - index = log2(SETS) bits.
  - tag = remaining bits.
- Per-line state: valid bit, tag, LINE_WORDS data words.
- Reset:
  - all valid bits cleared in one cycle; state goes to IDLE; beat counter = 0.
  - outputs during reset: stall=0, mem_req=0, mem_we=0, mem_be=0, cpu_rd=0.
  - reset during REFILL or WRITE abandons the transaction. mem_req is low from the next cycle. The partially filled line stays invalid.
- Misalignment (combinational):
  - H/HU with addr[0]=1, or W with addr[1:0]!=0, gives misaligned=1.
  - No cache or memory access occurs, stall=0, cpu_rd=0.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, load hit:
  - cpu_rd valid in the same cycle (combinational read); stall=0.
  - B/H sign-extend; BU/HU zero-extend; lane selected by addr[1:0].
- IDLE, load miss:
  - stall=1 combinationally in the same cycle; go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, beat, 2'b00}.
  - Each cycle with mem_ready: write mem_rd into word[beat], then beat++.
  - On the last beat: set tag and valid, clear beat, go to IDLE.
  - In the following IDLE cycle the access hits and stall drops.
  - stall=1 for the whole of REFILL.
- IDLE, store (hit or miss):
  - go to WRITE; stall=1.
  - On a hit, cached bytes are updated per byte enable at the IDLE->WRITE edge. On a miss there is no allocation.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = cpu_addr with [1:0] cleared.
  - mem_be: SB = 1<<addr[1:0]; SH = 0011 or 1100; SW = 1111.
  - mem_wd = cpu_wd shifted into the lane; unused lanes are 0.
  - On mem_ready: go to IDLE with stall=0 in the following cycle; the pipeline advances.
- Write-through with write-through-only policy: memory is always coherent; there is no dirty state.
- mem_ready outside REFILL/WRITE is ignored.
- cpu_req=0: no access, stall=0, cpu_rd=0.

Decomposition:
- Shared package dcache_pkg:
  - access-type enum matching funct3 (ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU).
  - FSM state enum.
  - function computing mem_be from type and addr.
- Sub-module lsu_align (combinational):
  - load extract/extend from word and addr[1:0].
  - store lane shift and byte-enable generation.
  - reused by the uncached I/O path.

Test Plan:
1. Reset, then LW at 0x00010000 with memory returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 and mem_ready 2 cycles after each request -> four beats at 0x10000, 0x10004, 0x10008, 0x1000C; stall high throughout; cpu_rd=0x11111111 on the hit cycle.
2. Line holds 0x80FF1234 at 0x00010010 -> LB 0x00010013 gives 0xFFFFFF80; LBU gives 0x00000080; LH 0x00010012 gives 0xFFFF80FF; LHU 0x00010010 gives 0x00001234; none stall.
3. SB 0xAB to 0x00010011 (hit) -> mem_we=1, mem_be=0010, mem_wd=0x0000AB00. Following LW 0x00010010 returns 0x80FFAB34 with no refill.
4. SW to the uncached 0x00020000 -> one write beat. Following LW to the same address misses and refills (no allocate).
5. LW 0x00010002 -> misaligned=1, mem_req=0, stall=0, cpu_rd=0.
6. Assert rst during beat 2 of a refill -> mem_req=0 next cycle. Re-issue the LW: it misses and does a full 4-beat refill.
